mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

MEM-stage load/store unit; consumes the EX/MEM pipeline-register outputs and is the data-memory-side counterpart of that register. It turns the MEM-stage instruction into a valid/ready data-bus transaction, aligns and extends load data, and stalls the front of the pipeline while the bus is busy. It also registers the MEM/WB stage outputs, with fault reporting for misaligned accesses, illegal widths and bus timeouts.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, max consecutive unacknowledged request cycles before abort; legal range 2..255.

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high
- alu_result_m  in  32  effective address / ALU result from EX/MEM
- rs2_m  in  32  store data
- rd_m  in  5  destination register
- RegWrite_m, MemRead_m, MemWrite_m, MemToReg_m  in  1 each  control from EX/MEM
- funct3_m  in  3  access width/sign (RV32I load/store encoding)
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = store
- dmem_addr  out  32  {alu_result_m[31:2], 2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte enables; 0 for loads
- dmem_ready  in  1  request accepted/complete; dmem_rdata valid same cycle
- dmem_rdata  in  32  word read data
- mem_stall  out  1  hold EX/MEM and all earlier stages
- alu_result_w, mem_data_w  out  32 each  to WB
- rd_w  out  5;  RegWrite_w, MemToReg_w  out  1 each
- fault_w  out  1  one-cycle fault flag, aligned with MEM/WB
- fault_cause_w  out  2  01 misaligned, 10 timeout, 11 illegal funct3, 00 none

## Operation
- access = MemRead_m | MemWrite_m (both set: treat as store). Fault check is combinational:
  - Misaligned: halfword with addr[0]=1, word with addr[1:0]≠0.
  - Illegal: load funct3 ∈ {011,110,111}; store funct3[2]=1 or funct3=011.
- On fault: no request, no stall. Next cycle MEM/WB gets a bubble (RegWrite_w=0) with fault_w=1 and the cause.
- Valid access: dmem_req=1 combinationally. addr/we/wdata/wstrb are stable while mem_stall holds EX/MEM.
- Store lanes:
  - SB: wstrb=0001<<addr[1:0], wdata={4{rs2[7:0]}}
  - SH: wstrb=0011<<{addr[1],1'b0}, wdata={2{rs2[15:0]}}
  - SW: 1111, rs2
- Load extract: shift rdata right by 8·addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through. Result goes to mem_data_w.
- FSM:
  - IDLE→WAIT when req & !ready.
  - WAIT→IDLE on ready, or on abort.
  - Wait counter (width clog2(TIMEOUT_CYCLES+1)) counts req cycles without ready; cleared in IDLE.
- mem_stall = req & !ready & !abort. abort = req & !ready & (req-cycle count reaches TIMEOUT_CYCLES).
- Abort: req drops next cycle. The MEM/WB entry is a bubble with cause 10. The bus slave must tolerate abandonment.
- ready and the timeout cycle coincide: completion wins, no fault.
- MEM/WB registers:
  - While mem_stall=1: load a bubble each cycle (RegWrite_w=0, fault_w=0), so WB never double-writes.
  - Otherwise: capture rd/RegWrite/MemToReg/alu_result plus the extracted load data.
  - Non-memory instructions pass straight through.

## Timing
- Reset:
  - All outputs 0; state IDLE; counter 0.
  - dmem_req is 0 during reset regardless of inputs.
  - Reset mid-WAIT abandons the transaction without a fault.
- Zero-wait access in MEM at cycle N (ready at N): no stall; MEM/WB valid at N+1.
- k wait cycles (ready at N+k):
  - mem_stall high N..N+k-1.
  - Bubbles into MEM/WB at N+1..N+k.
  - Result at N+k+1.
- Timeout:
  - Req high N..N+T-1 with no ready (T = TIMEOUT_CYCLES).
  - Stall high N..N+T-2, low at N+T-1.
  - fault_w=1, cause=10 at N+T.
- Back-to-back accesses: next instruction enters MEM at the cycle after completion. Its req may assert in that same cycle; no idle cycle is required.

## Structure
- Shared package pipe_pkg:
  - funct3 constants: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - fault-cause localparams: FAULT_NONE, FAULT_MISALIGN, FAULT_TIMEOUT, FAULT_ILLEGAL.
  - FSM state encoding.
- One combinational sub-module, lsu_align: fault detection, wstrb/wdata generation and load extract/extend. The top holds the FSM, counter and MEM/WB registers.

## Test plan
- LW addr 0x100, rdata 0xDEADBEEF, ready same cycle → no stall; next cycle mem_data_w=0xDEADBEEF, RegWrite_w=1.
- LB addr 0x103, rdata 0x80112233 → mem_data_w=0xFFFFFF80. LBU same → 0x00000080. LHU addr 0x102 → 0x00008011.
- SH addr 0x202, rs2=0x1234ABCD, ready after 3 wait cycles:
  - wstrb=1100, wdata=0xABCDABCD, held stable 4 cycles.
  - mem_stall high 3 cycles; three bubbles, then one MEM/WB entry.
- LW addr 0x101 → dmem_req stays 0, no stall; next cycle fault_w=1, cause=01, RegWrite_w=0.
- TIMEOUT_CYCLES=4, ready never asserts → req high 4 cycles, stall high 3; fault cause=10 after. Variant with ready on the 4th cycle → normal completion, no fault.
- Reset asserted during WAIT → next cycle dmem_req=0, all outputs 0, state IDLE. A fresh LW after reset completes normally.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the MEM stage.
// Holds the RV32I load/store funct3 encodings, the fault-cause codes
// reported into MEM/WB, the LSU bus FSM state type and the MEM/WB
// register bundle.
package pipe_pkg;

  // RV32I load funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // RV32I store funct3 encodings
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Fault causes carried alongside the MEM/WB entry
  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

  // Data-bus handshake state
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } lsu_state_e;

  // Everything the MEM/WB pipeline register carries to writeback
  typedef struct packed {
    logic [4:0]  rd;
    logic        regWrite;
    logic        memToReg;
    logic [31:0] aluResult;
    logic [31:0] memData;
    logic        fault;
    logic [1:0]  cause;
  } memwb_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the load/store unit.
// Ports:
//   addrLow_i    - effective address bits [1:0]
//   funct3_i     - RV32I access width/sign encoding
//   isStore_i    - 1 selects store legality rules, 0 load rules
//   rs2_i        - store source data
//   rdata_i      - word read from the data bus
//   misaligned_o - access crosses its natural alignment
//   illegal_o    - funct3 not a legal encoding for this access type
//   wstrb_o      - byte enables for a store
//   wdata_o      - store data replicated across all lanes it may hit
//   loadData_o   - load data shifted down and sign/zero extended
module lsu_align
  import pipe_pkg::*;
(
  input  logic [1:0]  addrLow_i,
  input  logic [2:0]  funct3_i,
  input  logic        isStore_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rdata_i,
  output logic        misaligned_o,
  output logic        illegal_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] loadData_o
);

  logic [31:0] shifted;

  // Width lives in funct3[1:0]; 11 never names a width, so it is
  // illegal for both directions and alignment is moot there.
  always_comb begin
    if (isStore_i) begin
      illegal_o = funct3_i[2] || (funct3_i[1:0] == 2'b11);
    end else begin
      illegal_o = (funct3_i[1:0] == 2'b11) || (funct3_i == 3'b110);
    end
    case (funct3_i[1:0])
      2'b01:   misaligned_o = addrLow_i[0];
      2'b10:   misaligned_o = (addrLow_i != 2'b00);
      default: misaligned_o = 1'b0;
    endcase
  end

  // Replicating the data lets the strobe alone pick the target lane.
  always_comb begin
    case (funct3_i[1:0])
      2'b00: begin
        wstrb_o = 4'b0001 << addrLow_i;
        wdata_o = {4{rs2_i[7:0]}};
      end
      2'b01: begin
        wstrb_o = 4'b0011 << {addrLow_i[1], 1'b0};
        wdata_o = {2{rs2_i[15:0]}};
      end
      default: begin
        wstrb_o = 4'b1111;
        wdata_o = rs2_i;
      end
    endcase
  end

  // Bring the addressed byte/halfword down to bit 0, then extend.
  always_comb begin
    shifted = rdata_i >> {addrLow_i, 3'b000};
    case (funct3_i)
      LB:      loadData_o = {{24{shifted[7]}}, shifted[7:0]};
      LH:      loadData_o = {{16{shifted[15]}}, shifted[15:0]};
      LBU:     loadData_o = {24'h0, shifted[7:0]};
      LHU:     loadData_o = {16'h0, shifted[15:0]};
      default: loadData_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit.
// Turns the EX/MEM instruction into a valid/ready data-bus request,
// stalls the front of the pipeline while the bus is busy, aborts after
// TIMEOUT_CYCLES unacknowledged request cycles, and registers MEM/WB.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   *_m                  - EX/MEM pipeline register outputs
//   dmem_*               - data bus (req/we/addr/wdata/wstrb out, ready/rdata in)
//   mem_stall            - hold EX/MEM and all earlier stages
//   *_w, fault_*_w       - MEM/WB pipeline register outputs
module mem_stage_lsu
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] rs2_m,
  input  logic [4:0]  rd_m,
  input  logic        RegWrite_m,
  input  logic        MemRead_m,
  input  logic        MemWrite_m,
  input  logic        MemToReg_m,
  input  logic [2:0]  funct3_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] alu_result_w,
  output logic [31:0] mem_data_w,
  output logic [4:0]  rd_w,
  output logic        RegWrite_w,
  output logic        MemToReg_w,
  output logic        fault_w,
  output logic [1:0]  fault_cause_w
);

  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
  // Counter value seen on the final permitted request cycle
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  lsu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  memwb_t          memwb_q, memwb_d;

  logic        access, isLoad, faultHit;
  logic        misaligned, illegal;
  logic [1:0]  faultCause;
  logic [3:0]  alignWstrb;
  logic [31:0] alignWdata, loadData;
  logic        reqValid, abort, memStall;

  // Read and write both set is treated as a store.
  assign access = MemRead_m | MemWrite_m;
  assign isLoad = MemRead_m & ~MemWrite_m;

  lsu_align u_align (
    .addrLow_i    (alu_result_m[1:0]),
    .funct3_i     (funct3_m),
    .isStore_i    (MemWrite_m),
    .rs2_i        (rs2_m),
    .rdata_i      (dmem_rdata),
    .misaligned_o (misaligned),
    .illegal_o    (illegal),
    .wstrb_o      (alignWstrb),
    .wdata_o      (alignWdata),
    .loadData_o   (loadData)
  );

  assign faultHit   = access & (misaligned | illegal);
  assign faultCause = illegal ? FAULT_ILLEGAL : FAULT_MISALIGN;

  // State and wait-cycle counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stay in WAIT exactly while the stage is stalled on the bus; ready,
  // abort or a withdrawn request all return to IDLE. The counter only
  // runs on stalled cycles, so it is zero whenever IDLE is entered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (memStall)  state_d = ST_WAIT;
      ST_WAIT: if (!memStall) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    cnt_d = memStall ? cnt_q + 1'b1 : '0;
  end

  // Request/abort/stall. Reset masks the request so the slave never sees
  // a stale instruction. When ready lands on the timeout cycle, ready wins.
  always_comb begin
    reqValid = access & ~faultHit & ~reset;
    abort    = reqValid & ~dmem_ready & (cnt_q == CntLast);
    memStall = reqValid & ~dmem_ready & ~abort;
  end

  assign dmem_req   = reqValid;
  assign dmem_we    = reqValid & MemWrite_m;
  assign dmem_addr  = reset ? 32'h0 : {alu_result_m[31:2], 2'b00};
  assign dmem_wdata = reset ? 32'h0 : alignWdata;
  assign dmem_wstrb = (reqValid & MemWrite_m) ? alignWstrb : 4'b0000;
  assign mem_stall  = memStall;

  // MEM/WB next value: bubble while stalled so WB never writes twice,
  // bubble plus cause on a fault or abort, otherwise the instruction.
  always_comb begin
    memwb_d = '0;
    if (memStall) begin
      memwb_d = '0;
    end else if (abort) begin
      memwb_d.fault = 1'b1;
      memwb_d.cause = FAULT_TIMEOUT;
    end else if (faultHit) begin
      memwb_d.fault = 1'b1;
      memwb_d.cause = faultCause;
    end else begin
      memwb_d.rd        = rd_m;
      memwb_d.regWrite  = RegWrite_m;
      memwb_d.memToReg  = MemToReg_m;
      memwb_d.aluResult = alu_result_m;
      memwb_d.memData   = isLoad ? loadData : 32'h0;
      memwb_d.cause     = FAULT_NONE;
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      memwb_q <= '0;
    end else begin
      memwb_q <= memwb_d;
    end
  end

  assign alu_result_w  = memwb_q.aluResult;
  assign mem_data_w    = memwb_q.memData;
  assign rd_w          = memwb_q.rd;
  assign RegWrite_w    = memwb_q.regWrite;
  assign MemToReg_w    = memwb_q.memToReg;
  assign fault_w       = memwb_q.fault;
  assign fault_cause_w = memwb_q.cause;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu (TIMEOUT_CYCLES = 4).
// Inputs change on the falling edge; combinational bus outputs are
// sampled 1 time unit later and MEM/WB outputs on the next falling edge.
module tb_mem_stage_lsu;
  import pipe_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_result_m, rs2_m;
  logic [4:0]  rd_m;
  logic        RegWrite_m, MemRead_m, MemWrite_m, MemToReg_m;
  logic [2:0]  funct3_m;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic [31:0] alu_result_w, mem_data_w;
  logic [4:0]  rd_w;
  logic        RegWrite_w, MemToReg_w, fault_w;
  logic [1:0]  fault_cause_w;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .alu_result_m(alu_result_m), .rs2_m(rs2_m), .rd_m(rd_m),
    .RegWrite_m(RegWrite_m), .MemRead_m(MemRead_m), .MemWrite_m(MemWrite_m),
    .MemToReg_m(MemToReg_m), .funct3_m(funct3_m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall),
    .alu_result_w(alu_result_w), .mem_data_w(mem_data_w), .rd_w(rd_w),
    .RegWrite_w(RegWrite_w), .MemToReg_w(MemToReg_w),
    .fault_w(fault_w), .fault_cause_w(fault_cause_w)
  );

  // Drive one EX/MEM instruction onto the stage inputs
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] rs2,
                               input logic [4:0] rd, input logic regW,
                               input logic memR, input logic memW,
                               input logic m2r, input logic [2:0] f3);
    alu_result_m = addr;
    rs2_m        = rs2;
    rd_m         = rd;
    RegWrite_m   = regW;
    MemRead_m    = memR;
    MemWrite_m   = memW;
    MemToReg_m   = m2r;
    funct3_m     = f3;
  endtask

  // Reference model: access rules computed arithmetically per byte lane
  function automatic bit refIllegal(input bit isStore, input int f3);
    if (isStore) return (f3 > 2);
    return (f3 == 3) || (f3 == 6) || (f3 == 7);
  endfunction

  function automatic bit refMisaligned(input int off, input int f3);
    int size;
    size = 1 << (f3 % 4);
    return (off % size) != 0;
  endfunction

  function automatic logic [3:0] refStrb(input int off, input int f3);
    int size;
    logic [3:0] s;
    size = 1 << (f3 % 4);
    for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < off + size);
    return s;
  endfunction

  function automatic logic [31:0] refWdata(input logic [31:0] rs2, input int f3);
    int size;
    logic [31:0] w;
    size = 1 << (f3 % 4);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % size) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] rdata, input int off, input int f3);
    logic [31:0] s, b, h;
    s = rdata >> (8 * off);
    b = s % 256;
    h = s % 65536;
    case (f3)
      0: return (b >= 128) ? b + 32'hFFFFFF00 : b;
      1: return (h >= 32768) ? h + 32'hFFFF0000 : h;
      4: return b;
      5: return h;
      default: return rdata;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(32'h100, 32'h55, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, LW);
    dmem_ready = 1'b0;
    #1;
    vectors++;
    if (dmem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_req: got %b expected 0", dmem_req); end
    vectors++;
    if (mem_stall !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall: got %b expected 0", mem_stall); end
    @(negedge clk);
    vectors++;
    if ({rd_w, RegWrite_w, MemToReg_w, alu_result_w, mem_data_w, fault_w, fault_cause_w} !== 76'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_memwb: got %h expected 0",
               {rd_w, RegWrite_w, MemToReg_w, alu_result_w, mem_data_w, fault_w, fault_cause_w});
    end
    reset = 1'b0;
  endtask

  task automatic test_loads();
    logic [31:0] addrs [4] = '{32'h100, 32'h103, 32'h103, 32'h102};
    logic [2:0]  f3s   [4] = '{LW, LB, LBU, LHU};
    logic [31:0] rdats [4] = '{32'hDEADBEEF, 32'h80112233, 32'h80112233, 32'h80112233};
    logic [31:0] exps  [4] = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00000080, 32'h00008011};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(addrs[i], 32'h0, 5'(i + 1), 1'b1, 1'b1, 1'b0, 1'b1, f3s[i]);
      dmem_ready = 1'b1;
      dmem_rdata = rdats[i];
      #1;
      vectors++;
      if (dmem_req !== 1'b1 || mem_stall !== 1'b0) begin
        miscompares++; $display("[TB] FAIL load_req_stall[%0d]: got %b%b expected 10", i, dmem_req, mem_stall);
      end
      @(negedge clk);
      vectors++;
      if (mem_data_w !== exps[i]) begin
        miscompares++; $display("[TB] FAIL load_data[%0d]: got %h expected %h", i, mem_data_w, exps[i]);
      end
      vectors++;
      if (RegWrite_w !== 1'b1 || rd_w !== 5'(i + 1)) begin
        miscompares++; $display("[TB] FAIL load_wb[%0d]: got %b/%0d expected 1/%0d", i, RegWrite_w, rd_w, i + 1);
      end
    end
  endtask

  task automatic test_store_wait();
    int stalls = 0;
    applyStimulus(32'h202, 32'h1234ABCD, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, SH);
    for (int c = 0; c <= 3; c++) begin
      dmem_ready = (c == 3);
      dmem_rdata = $urandom;
      #1;
      if (mem_stall === 1'b1) stalls++;
      vectors++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h200) begin
        miscompares++; $display("[TB] FAIL sh_bus[%0d]: got %b%b %h expected 11 00000200", c, dmem_req, dmem_we, dmem_addr);
      end
      vectors++;
      if (dmem_wstrb !== 4'b1100 || dmem_wdata !== 32'hABCDABCD) begin
        miscompares++; $display("[TB] FAIL sh_lanes[%0d]: got %b %h expected 1100 abcdabcd", c, dmem_wstrb, dmem_wdata);
      end
      @(negedge clk);
    end
    vectors++;
    if (stalls != 3) begin miscompares++; $display("[TB] FAIL sh_stall_count: got %0d expected 3", stalls); end
    vectors++;
    if (alu_result_w !== 32'h202 || fault_w !== 1'b0) begin
      miscompares++; $display("[TB] FAIL sh_entry: got %h/%b expected 00000202/0", alu_result_w, fault_w);
    end
  endtask

  task automatic test_misaligned();
    applyStimulus(32'h101, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, LW);
    dmem_ready = 1'b1;
    #1;
    vectors++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      miscompares++; $display("[TB] FAIL mis_req_stall: got %b%b expected 00", dmem_req, mem_stall);
    end
    @(negedge clk);
    vectors++;
    if (fault_w !== 1'b1 || fault_cause_w !== FAULT_MISALIGN || RegWrite_w !== 1'b0) begin
      miscompares++; $display("[TB] FAIL mis_fault: got %b/%b/%b expected 1/01/0", fault_w, fault_cause_w, RegWrite_w);
    end
    applyStimulus(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    vectors++;
    if (fault_w !== 1'b0) begin miscompares++; $display("[TB] FAIL mis_one_cycle: got %b expected 0", fault_w); end
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    // Ready never comes: abort on the T-th request cycle
    applyStimulus(32'h300, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, LW);
    dmem_ready = 1'b0;
    for (int c = 0; c < T; c++) begin
      #1;
      vectors++;
      if (dmem_req !== 1'b1 || mem_stall !== (c < T - 1)) begin
        miscompares++; $display("[TB] FAIL to_req_stall[%0d]: got %b%b expected 1%b", c, dmem_req, mem_stall, c < T - 1);
      end
      @(negedge clk);
    end
    vectors++;
    if (fault_w !== 1'b1 || fault_cause_w !== FAULT_TIMEOUT || RegWrite_w !== 1'b0) begin
      miscompares++; $display("[TB] FAIL to_fault: got %b/%b/%b expected 1/10/0", fault_w, fault_cause_w, RegWrite_w);
    end
    // Ready on the final permitted cycle: completion wins
    applyStimulus(32'h304, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, LW);
    rd = $urandom;
    for (int c = 0; c < T; c++) begin
      dmem_ready = (c == T - 1);
      dmem_rdata = rd;
      @(negedge clk);
    end
    vectors++;
    if (fault_w !== 1'b0 || RegWrite_w !== 1'b1 || mem_data_w !== rd) begin
      miscompares++; $display("[TB] FAIL to_late_ready: got %b/%b/%h expected 0/1/%h", fault_w, RegWrite_w, mem_data_w, rd);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd;
    applyStimulus(32'h400, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, LW);
    dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rst_wait_req: got %b%b expected 00", dmem_req, mem_stall);
    end
    @(negedge clk);
    vectors++;
    if ({rd_w, RegWrite_w, MemToReg_w, alu_result_w, mem_data_w, fault_w, fault_cause_w} !== 76'h0) begin
      miscompares++; $display("[TB] FAIL rst_wait_memwb: got %h expected 0",
                              {rd_w, RegWrite_w, MemToReg_w, alu_result_w, mem_data_w, fault_w, fault_cause_w});
    end
    reset = 1'b0;
    // Fresh load with T-1 waits completes only if the counter was cleared
    applyStimulus(32'h408, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, LW);
    rd = $urandom;
    dmem_rdata = rd;
    for (int c = 0; c < T; c++) begin
      dmem_ready = (c == T - 1);
      #1;
      vectors++;
      if (mem_stall !== (c < T - 1)) begin
        miscompares++; $display("[TB] FAIL rst_fresh_stall[%0d]: got %b expected %b", c, mem_stall, c < T - 1);
      end
      @(negedge clk);
    end
    vectors++;
    if (fault_w !== 1'b0 || RegWrite_w !== 1'b1 || rd_w !== 5'd9 || mem_data_w !== rd) begin
      miscompares++; $display("[TB] FAIL rst_fresh_done: got %b/%b/%0d/%h expected 0/1/9/%h",
                              fault_w, RegWrite_w, rd_w, mem_data_w, rd);
    end
  endtask

  task automatic test_random(input int n);
    for (int t = 0; t < n; t++) begin
      int kind, k, off, f3, last, cause;
      bit memR, memW, regW, m2r, acc, bad, ill;
      logic [31:0] addr, rs2, rdataV;
      logic [4:0]  rd;
      kind   = $urandom_range(0, 9);
      addr   = $urandom;
      rs2    = $urandom;
      rdataV = $urandom;
      rd     = 5'($urandom);
      regW   = 1'($urandom);
      m2r    = 1'($urandom);
      f3     = $urandom_range(0, 7);
      k      = $urandom_range(0, 5);
      memR   = (kind >= 2 && kind <= 5) || (kind == 9);
      memW   = (kind >= 6);
      acc    = memR || memW;
      off    = addr % 4;
      ill    = refIllegal(memW, f3);
      bad    = acc && (ill || refMisaligned(off, f3));
      cause  = ill ? 3 : 1;
      applyStimulus(addr, rs2, rd, regW, memR, memW, m2r, 3'(f3));
      if (!acc || bad) begin
        dmem_ready = 1'($urandom);
        dmem_rdata = rdataV;
        #1;
        vectors++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
          miscompares++; $display("[TB] FAIL rand_noreq[%0d]: got %b%b expected 00", t, dmem_req, mem_stall);
        end
        @(negedge clk);
        vectors++;
        if (bad && (fault_w !== 1'b1 || fault_cause_w !== 2'(cause) || RegWrite_w !== 1'b0)) begin
          miscompares++; $display("[TB] FAIL rand_fault[%0d]: got %b/%b/%b expected 1/%0d/0", t, fault_w, fault_cause_w, RegWrite_w, cause);
        end else if (!bad && (fault_w !== 1'b0 || RegWrite_w !== regW || rd_w !== rd || alu_result_w !== addr)) begin
          miscompares++; $display("[TB] FAIL rand_pass[%0d]: got %b/%b/%0d/%h expected 0/%b/%0d/%h",
                                  t, fault_w, RegWrite_w, rd_w, alu_result_w, regW, rd, addr);
        end
      end else begin
        last = (k < T) ? k : T - 1;
        for (int c = 0; c <= last; c++) begin
          dmem_ready = (c == k);
          dmem_rdata = (c == k) ? rdataV : $urandom;
          #1;
          vectors++;
          if (dmem_req !== 1'b1 || mem_stall !== (c < last) || dmem_we !== memW || dmem_addr !== {addr[31:2], 2'b00}) begin
            miscompares++; $display("[TB] FAIL rand_bus[%0d.%0d]: got %b%b%b %h expected 1%b%b %h",
                                    t, c, dmem_req, mem_stall, dmem_we, dmem_addr, c < last, memW, {addr[31:2], 2'b00});
          end
          vectors++;
          if (memW && (dmem_wstrb !== refStrb(off, f3) || dmem_wdata !== refWdata(rs2, f3))) begin
            miscompares++; $display("[TB] FAIL rand_store[%0d.%0d]: got %b %h expected %b %h",
                                    t, c, dmem_wstrb, dmem_wdata, refStrb(off, f3), refWdata(rs2, f3));
          end else if (!memW && dmem_wstrb !== 4'b0000) begin
            miscompares++; $display("[TB] FAIL rand_load_strb[%0d.%0d]: got %b expected 0000", t, c, dmem_wstrb);
          end
          @(negedge clk);
          vectors++;
          if (c < last) begin
            if (RegWrite_w !== 1'b0 || fault_w !== 1'b0) begin
              miscompares++; $display("[TB] FAIL rand_bubble[%0d.%0d]: got %b/%b expected 0/0", t, c, RegWrite_w, fault_w);
            end
          end else if (k >= T) begin
            if (fault_w !== 1'b1 || fault_cause_w !== FAULT_TIMEOUT || RegWrite_w !== 1'b0) begin
              miscompares++; $display("[TB] FAIL rand_timeout[%0d]: got %b/%b/%b expected 1/10/0", t, fault_w, fault_cause_w, RegWrite_w);
            end
          end else begin
            if (fault_w !== 1'b0 || RegWrite_w !== regW || rd_w !== rd || alu_result_w !== addr ||
                (memR && !memW && mem_data_w !== refLoad(rdataV, off, f3))) begin
              miscompares++; $display("[TB] FAIL rand_done[%0d]: got %b/%b/%0d/%h/%h expected 0/%b/%0d/%h/%h",
                                      t, fault_w, RegWrite_w, rd_w, alu_result_w, mem_data_w,
                                      regW, rd, addr, refLoad(rdataV, off, f3));
            end
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    test_reset();
    test_loads();
    test_store_wait();
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    test_random(300);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
